// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: one outstanding instruction fetch, registered buffer to decode, jump/kill redirect.
// Optional trap redirect ports (priority over jump) are enabled by YSYX_22050368_TRAP_EN.
module pc_fetch_ctrl #(
  parameter int unsigned          AddrW        = 32,
  parameter logic [AddrW-1:0]     CpuResetAddr = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_flag_i,
  input  logic [AddrW-1:0] jump_addr_i,
`ifdef YSYX_22050368_TRAP_EN
  input  logic             trap_flag_i,
  input  logic [AddrW-1:0] trap_addr_i,
`endif
  input  logic             hold_i,
  output logic             ifu_req_o,
  output logic [AddrW-1:0] ifu_addr_o,
  input  logic             ifu_gnt_i,
  input  logic             ifu_rvalid_i,
  input  logic [AddrW-1:0] ifu_rdata_i,
  output logic             inst_valid_o,
  output logic [AddrW-1:0] inst_o,
  output logic [AddrW-1:0] inst_addr_o,
  input  logic             id_ready_i,
  output logic [AddrW-1:0] pc_o,
  output logic [31:0]      fetch_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_e;

  state_e           state, state_nxt;
  logic [AddrW-1:0] pc, pc_nxt;
  logic [AddrW-1:0] req_addr;
  logic [AddrW-1:0] inst_q, inst_addr_q;
  logic [31:0]      fetch_cnt;
  logic             kill, kill_nxt;
  logic             redirect;
  logic [AddrW-1:0] redirect_addr;
  logic             capture;
  logic             handshake;

`ifdef YSYX_22050368_TRAP_EN
  assign redirect      = trap_flag_i | jump_flag_i;
  assign redirect_addr = trap_flag_i ? trap_addr_i : jump_addr_i;
`else
  assign redirect      = jump_flag_i;
  assign redirect_addr = jump_addr_i;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) pc_nxt = redirect_addr;
        if (!hold_i) state_nxt = REQ;
      end
      REQ: begin
        // The request already on the bus stays put; a redirect only marks its reply for discard.
        if (redirect) begin
          pc_nxt   = redirect_addr;
          kill_nxt = 1'b1;
        end
        if (ifu_gnt_i) state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect) pc_nxt = redirect_addr;
        if (ifu_rvalid_i) begin
          if (kill || redirect) begin
            kill_nxt  = 1'b0;
            state_nxt = hold_i ? IDLE : REQ;
          end else begin
            capture   = 1'b1;
            state_nxt = OUT;
          end
        end else if (redirect) begin
          kill_nxt = 1'b1;
        end
      end
      OUT: begin
        if (redirect) begin
          pc_nxt    = redirect_addr;
          state_nxt = hold_i ? IDLE : REQ;
        end else if (id_ready_i) begin
          handshake = 1'b1;
          pc_nxt    = pc + AddrW'(4);
          state_nxt = hold_i ? IDLE : REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= CpuResetAddr;
      req_addr    <= CpuResetAddr;
      inst_q      <= '0;
      inst_addr_q <= '0;
      fetch_cnt   <= '0;
      kill        <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      kill  <= kill_nxt;
      // Fetch address is frozen on entry to REQ so later redirects cannot disturb it.
      if (state_nxt == REQ && state != REQ) req_addr <= pc_nxt;
      if (capture) begin
        inst_q      <= ifu_rdata_i;
        inst_addr_q <= req_addr;
      end
      if (handshake) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign ifu_req_o    = (state == REQ);
  assign ifu_addr_o   = req_addr;
  assign inst_valid_o = (state == OUT) && !redirect;
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign pc_o         = pc;
  assign fetch_cnt_o  = fetch_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with fetch-address and delivered-instruction scoreboards.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
`ifdef YSYX_22050368_TRAP_EN
  logic        trap_flag_i;
  logic [31:0] trap_addr_i;
`endif
  logic        hold_i;
  logic        ifu_req_o;
  logic [31:0] ifu_addr_o;
  logic        ifu_gnt_i;
  logic        ifu_rvalid_i;
  logic [31:0] ifu_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        id_ready_i;
  logic [31:0] pc_o;
  logic [31:0] fetch_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
`ifdef YSYX_22050368_TRAP_EN
    .trap_flag_i  (trap_flag_i),
    .trap_addr_i  (trap_addr_i),
`endif
    .hold_i       (hold_i),
    .ifu_req_o    (ifu_req_o),
    .ifu_addr_o   (ifu_addr_o),
    .ifu_gnt_i    (ifu_gnt_i),
    .ifu_rvalid_i (ifu_rvalid_i),
    .ifu_rdata_i  (ifu_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .id_ready_i   (id_ready_i),
    .pc_o         (pc_o),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the pending request against the address scoreboard and grants it.
  task automatic grant(output logic [31:0] a);
    a = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
    check("ifu_req", 32'(ifu_req_o), 32'd1);
    check("ifu_addr", ifu_addr_o, a);
    ifu_gnt_i = 1'b1;
    tick();
    ifu_gnt_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] a, input logic [31:0] data, input bit deliver);
    ifu_rvalid_i = 1'b1;
    ifu_rdata_i  = data;
    if (deliver) exp_inst_q.push_back({a, data});
    tick();
    ifu_rvalid_i = 1'b0;
    ifu_rdata_i  = '0;
  endtask

  // Compares the buffered instruction with the scoreboard, then lets the handshake edge pass.
  task automatic consume();
    logic [63:0] e;
    check("sb_nonempty", 32'(exp_inst_q.size() != 0), 32'd1);
    e = (exp_inst_q.size() != 0) ? exp_inst_q.pop_front() : 64'd0;
    check("inst_valid", 32'(inst_valid_o), 32'd1);
    check("inst", inst_o, e[31:0]);
    check("inst_addr", inst_addr_o, e[63:32]);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] last_inst;
    logic [31:0] last_addr;
    logic [63:0] e;

    rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = '0; hold_i = 1'b0;
    ifu_gnt_i = 1'b0; ifu_rvalid_i = 1'b0; ifu_rdata_i = '0; id_ready_i = 1'b1;
`ifdef YSYX_22050368_TRAP_EN
    trap_flag_i = 1'b0; trap_addr_i = '0;
`endif
    last_inst = '0; last_addr = '0;
    tick(); tick();

    check("rst_req", 32'(ifu_req_o), 32'd0);
    check("rst_pc", pc_o, 32'h8000_0000);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_inst_addr", inst_addr_o, 32'd0);
    check("rst_cnt", fetch_cnt_o, 32'd0);

    // First cycle after release is IDLE, request appears in the second.
    rst = 1'b0;
    check("idle_after_rst", 32'(ifu_req_o), 32'd0);
    tick();

    // Request held without grant, hold_i raised: must not move.
    hold_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("stall_req", 32'(ifu_req_o), 32'd1);
      check("stall_addr", ifu_addr_o, 32'h8000_0000);
      tick();
    end
    hold_i = 1'b0;

    // Three back-to-back fetches.
    exp_addr_q.push_back(32'h8000_0000);
    exp_addr_q.push_back(32'h8000_0004);
    exp_addr_q.push_back(32'h8000_0008);
    for (int i = 0; i < 3; i++) begin
      grant(a);
      last_inst = 32'h0000_0013 + 32'(i << 7);
      last_addr = a;
      respond(a, last_inst, 1'b1);
      consume();
    end
    check("cnt_after3", fetch_cnt_o, 32'd3);
    check("pc_after3", pc_o, 32'h8000_000C);

    // Jump while in WAIT kills the outstanding response.
    exp_addr_q.push_back(32'h8000_000C);
    grant(a);
    jump_flag_i = 1'b1; jump_addr_i = 32'h8000_1000;
    exp_addr_q.push_back(32'h8000_1000);
    tick();
    jump_flag_i = 1'b0;
    check("pc_after_jump", pc_o, 32'h8000_1000);
    respond(a, 32'hDEAD_BEEF, 1'b0);
    check("killed_valid", 32'(inst_valid_o), 32'd0);
    check("killed_inst", inst_o, last_inst);
    check("killed_inst_addr", inst_addr_o, last_addr);
    check("killed_cnt", fetch_cnt_o, 32'd3);

    // Decode stalls 4 cycles, then a jump on the 5th drops the buffered word.
    grant(a);
    id_ready_i = 1'b0;
    respond(a, 32'h00A0_0093, 1'b1);
    e = (exp_inst_q.size() != 0) ? exp_inst_q.pop_front() : 64'd0;
    for (int k = 0; k < 4; k++) begin
      check("stall_valid", 32'(inst_valid_o), 32'd1);
      check("stall_inst", inst_o, e[31:0]);
      check("stall_inst_addr", inst_addr_o, e[63:32]);
      check("stall_no_req", 32'(ifu_req_o), 32'd0);
      tick();
    end
    jump_flag_i = 1'b1; jump_addr_i = 32'h8000_2000; id_ready_i = 1'b1;
    exp_addr_q.push_back(32'h8000_2000);
    #1;
    check("jump_masks_valid", 32'(inst_valid_o), 32'd0);
    tick();
    jump_flag_i = 1'b0;
    check("jump_cnt_same", fetch_cnt_o, 32'd3);
    check("jump_pc", pc_o, 32'h8000_2000);

    // Jump coincident with grant: transaction completes but is discarded.
    a = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
    check("gj_req", 32'(ifu_req_o), 32'd1);
    check("gj_addr", ifu_addr_o, a);
    ifu_gnt_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h8000_3000;
    exp_addr_q.push_back(32'h8000_3000);
    tick();
    ifu_gnt_i = 1'b0; jump_flag_i = 1'b0;
    respond(a, 32'h1111_1111, 1'b0);
    check("gj_valid", 32'(inst_valid_o), 32'd0);

    // Reset in WAIT; a late response after release is ignored.
    grant(a);
    rst = 1'b1;
    #1;
    check("mid_rst_pc", pc_o, 32'h8000_0000);
    check("mid_rst_req", 32'(ifu_req_o), 32'd0);
    check("mid_rst_cnt", fetch_cnt_o, 32'd0);
    tick();
    rst = 1'b0;
    ifu_rvalid_i = 1'b1; ifu_rdata_i = 32'hCAFE_BABE;
    tick();
    check("late_rv_valid", 32'(inst_valid_o), 32'd0);
    check("late_rv_pc", pc_o, 32'h8000_0000);
    tick();
    ifu_rvalid_i = 1'b0; ifu_rdata_i = '0;
    check("late_rv_valid2", 32'(inst_valid_o), 32'd0);
    check("late_rv_inst", inst_o, 32'd0);

    // Handshake with hold_i set parks in IDLE until hold drops.
    exp_addr_q.push_back(32'h8000_0000);
    grant(a);
    respond(a, 32'h0000_0013, 1'b1);
    hold_i = 1'b1;
    consume();
    check("hold_idle_req", 32'(ifu_req_o), 32'd0);
    check("hold_cnt", fetch_cnt_o, 32'd1);
    check("hold_pc", pc_o, 32'h8000_0004);
    tick();
    check("hold_idle_req2", 32'(ifu_req_o), 32'd0);
    hold_i = 1'b0;
    exp_addr_q.push_back(32'h8000_0004);
    tick();
    grant(a);

`ifdef YSYX_22050368_TRAP_EN
    trap_flag_i = 1'b1; trap_addr_i = 32'h8000_0100;
    jump_flag_i = 1'b1; jump_addr_i = 32'h8000_2000;
    ifu_rvalid_i = 1'b1; ifu_rdata_i = 32'h2222_2222;
    tick();
    trap_flag_i = 1'b0; jump_flag_i = 1'b0; ifu_rvalid_i = 1'b0;
    check("trap_valid", 32'(inst_valid_o), 32'd0);
    check("trap_req", 32'(ifu_req_o), 32'd1);
    check("trap_addr", ifu_addr_o, 32'h8000_0100);
`else
    respond(a, 32'h0010_0093, 1'b1);
    consume();
    check("final_cnt", fetch_cnt_o, 32'd2);
    check("final_pc", pc_o, 32'h8000_0008);
`endif
    check("sb_drained", 32'(exp_inst_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
